// File: rtl/sine_sample_streamer_if.sv
// -----------------------------------------------------------------------------
// sine_sample_streamer_if
//
// Purpose:
//     Groups the two buses of the sine sample streamer into one bundle:
//       - the quarter-wave ROM read bus (address out, data back one edge
//         after the ROM samples the address), and
//       - the downstream sample stream (valid/ready handshake).
//
// Signals:
//     rom_addr      ADDR_W   streamer -> ROM    registered read address
//     rom_data      DATA_W   ROM -> streamer    registered ROM output
//     sample        DATA_W   streamer -> sink   FIFO head sample
//     sample_valid  1        streamer -> sink   FIFO non-empty
//     sample_ready  1        sink -> streamer   sink accepts this cycle
//
// Modports:
//     master  the streamer side (drives rom_addr, sample, sample_valid)
//     slave   the ROM + sink side (drives rom_data, sample_ready)
// -----------------------------------------------------------------------------
interface sine_sample_streamer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 9
);

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output rom_addr,
        input  rom_data,
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  sample,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sine_sample_streamer.sv
// -----------------------------------------------------------------------------
// sine_sample_streamer
//
// Purpose:
//     Read-side sequencer for a quarter-wave sine ROM. A phase accumulator of
//     ADDR_W+2 bits walks the full period; the top two bits select the
//     quadrant and the low ADDR_W bits index the quarter wave. Each issued
//     read is tagged with whether its sample belongs to the negative half,
//     the tag travels down a two-stage pipe alongside the ROM latency, and
//     the returned data is mirrored (by address) or inverted (by value)
//     before being written into a 4-entry output FIFO that feeds a
//     valid/ready stream.
//
// Ports:
//     i_clk     in   1       sole clock, rising edge
//     i_reset   in   1       synchronous active-high reset, clears all state
//     i_enable  in   1       permits issuing new ROM reads
//     i_step    in   ADDR_W  phase increment per issued sample (0 holds)
//     bus       master modport of sine_sample_streamer_if
//                   rom_addr / rom_data : quarter-wave ROM read bus
//                   sample / sample_valid / sample_ready : output stream
//
// Flow control:
//     A read is issued only while (fifo_count + reads in flight) < 4, so every
//     issued read is guaranteed a FIFO slot when it returns. The FIFO can
//     therefore never overflow and no returned sample is ever dropped.
// -----------------------------------------------------------------------------
module sine_sample_streamer #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 9,
    parameter int MAX_VALUE = 511
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_step,
    sine_sample_streamer_if.master bus
);

    localparam int PHASE_W    = ADDR_W + 2;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 3;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [PHASE_W-1:0] r_phase;
    logic [ADDR_W-1:0]  r_rom_addr;

    // Tag pipe: stage 1 covers the ROM's own register, stage 2 marks the
    // cycle in which rom_data belongs to the tagged read.
    logic               r_tag1_vld;
    logic               r_tag1_inv;
    logic               r_tag2_vld;
    logic               r_tag2_inv;

    logic [DATA_W-1:0]  r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_fifo_count;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic [1:0]         w_quad;
    logic [ADDR_W-1:0]  w_index;
    logic [ADDR_W-1:0]  w_addr_next;
    logic [PHASE_W-1:0] w_step_ext;
    logic [CNT_W-1:0]   w_inflight;
    logic [CNT_W:0]     w_credit_used;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic [DATA_W-1:0]  w_push_data;

    assign w_quad  = r_phase[PHASE_W-1 -: 2];
    assign w_index = r_phase[ADDR_W-1:0];

    // Odd quadrants run the quarter wave backwards. For an all-ones last
    // index, (2**ADDR_W - 1) - i is simply the bitwise complement of i.
    assign w_addr_next = w_quad[0] ? ~w_index : w_index;

    assign w_step_ext = {2'b00, i_step};

    assign w_inflight    = {{(CNT_W-1){1'b0}}, r_tag1_vld}
                         + {{(CNT_W-1){1'b0}}, r_tag2_vld};
    assign w_credit_used = {1'b0, r_fifo_count} + {1'b0, w_inflight};

    // Credit check uses registered counts only; a pop in the same cycle frees
    // its slot one cycle later, which still sustains one issue per cycle.
    assign w_issue = i_enable && (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));

    assign w_not_empty = (r_fifo_count != '0);
    assign w_push      = r_tag2_vld;
    assign w_pop       = w_not_empty && bus.sample_ready;

    // Negative half: reflect the value about full scale. The ROM never holds
    // more than MAX_VALUE, so this cannot wrap.
    assign w_push_data = r_tag2_inv ? (DATA_W'(MAX_VALUE) - bus.rom_data)
                                    : bus.rom_data;

    // -------------------------------------------------------------------------
    // Outputs: all taken straight from registers, no path from sample_ready.
    // -------------------------------------------------------------------------
    assign bus.rom_addr     = r_rom_addr;
    assign bus.sample       = r_fifo_mem[r_rd_ptr];
    assign bus.sample_valid = w_not_empty;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase      <= '0;
            r_rom_addr   <= '0;
            r_tag1_vld   <= 1'b0;
            r_tag1_inv   <= 1'b0;
            r_tag2_vld   <= 1'b0;
            r_tag2_inv   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            // Cleared so the stream output reads 0 straight after reset.
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fifo_mem[k] <= '0;
            end
        end else begin
            // Issue stage
            if (w_issue) begin
                r_rom_addr <= w_addr_next;
                r_phase    <= r_phase + w_step_ext;
            end

            // Tag pipe advances every cycle; bubbles carry valid=0.
            r_tag1_vld <= w_issue;
            r_tag1_inv <= w_issue && w_quad[1];
            r_tag2_vld <= r_tag1_vld;
            r_tag2_inv <= r_tag1_inv;

            // FIFO write side
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end

            // FIFO read side
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            // Occupancy; push+pop together leaves it unchanged.
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_sample_streamer.sv
module tb_sine_sample_streamer;

    logic       clk;
    logic       i_reset;
    logic       i_enable;
    logic [6:0] i_step;

    logic [8:0] rom [128];

    int checks   = 0;
    int failures = 0;

    sine_sample_streamer_if bus ();

    sine_sample_streamer dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_step   (i_step),
        .bus      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quarter-wave ROM with one registered read stage.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: every read still owed to the sink is one queue
    // entry holding its final value and the edge after which it becomes
    // visible (issue edge + 2). Credits = entries in the queue.
    // ------------------------------------------------------------------
    typedef struct {
        int val;
        int vis;
    } ent_t;

    ent_t q[$];
    int   m_phase = 0;
    int   m_addr  = 0;
    int   cyc     = 0;

    always @(posedge clk) begin
        bit   rst, en, rdy, head_vis, exp_v;
        int   st, n, qd, idx;
        ent_t e;
        rst = i_reset;
        en  = i_enable;
        rdy = bus.sample_ready;
        st  = int'(i_step);
        cyc++;
        if (rst) begin
            q.delete();
            m_phase = 0;
            m_addr  = 0;
        end else begin
            n = q.size();
            head_vis = (n > 0) && (q[0].vis <= cyc - 1);
            if (head_vis && rdy) void'(q.pop_front());
            if (en && n < 4) begin
                qd  = m_phase / 128;
                idx = m_phase % 128;
                m_addr = (qd % 2 == 1) ? 127 - idx : idx;
                e.val = (qd >= 2) ? 511 - int'(rom[m_addr]) : int'(rom[m_addr]);
                e.vis = cyc + 2;
                q.push_back(e);
                m_phase = (m_phase + st) % 512;
            end
        end
        #1;
        exp_v = (q.size() > 0) && (q[0].vis <= cyc);
        check("model_valid", int'(bus.sample_valid), int'(exp_v));
        check("model_rom_addr", int'(bus.rom_addr), m_addr);
        if (exp_v) check("model_sample", int'(bus.sample), q[0].val);
        else if (rst) check("model_sample_reset", int'(bus.sample), 0);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on the falling edge, outputs are
    // observed 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic cycle(input bit rst, input bit en, input int st, input bit rdy);
        @(negedge clk);
        i_reset          = rst;
        i_enable         = en;
        i_step           = 7'(st);
        bus.sample_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Expected full-period sample for ROM contents rom[i] = 4*i, step 1.
    function automatic int period_value(input int n);
        int p;
        p = n % 512;
        if (p < 128)      return 4 * p;
        else if (p < 256) return 508 - 4 * (p - 128);
        else if (p < 384) return 511 - 4 * (p - 256);
        else              return 3 + 4 * (p - 384);
    endfunction

    initial begin
        int n, first_valid, found;

        for (int i = 0; i < 128; i++) rom[i] = 9'(4 * i);
        i_reset          = 1'b1;
        i_enable         = 1'b0;
        i_step           = 7'd1;
        bus.sample_ready = 1'b1;

        // Reset values
        cycle(1, 0, 1, 1);
        cycle(1, 0, 1, 1);
        check("reset_valid", int'(bus.sample_valid), 0);
        check("reset_rom_addr", int'(bus.rom_addr), 0);
        check("reset_sample", int'(bus.sample), 0);

        // Full period twice with step 1, ready held high
        n = 0;
        first_valid = -1;
        for (int c = 1; c <= 1200 && n < 1024; c++) begin
            cycle(0, 1, 1, 1);
            if (bus.sample_valid) begin
                if (first_valid < 0) first_valid = c;
                check("period_sample", int'(bus.sample), period_value(n));
                n++;
            end
        end
        check("first_valid_edge", first_valid, 3);
        check("period_count", n, 1024);

        // Backpressure mid-stream, then release
        repeat (10) cycle(0, 1, 1, 0);
        repeat (30) cycle(0, 1, 1, 1);

        // Enable low for 5 cycles with ready high
        repeat (5) cycle(0, 0, 1, 1);
        repeat (20) cycle(0, 1, 1, 1);

        // step=5 applied at phase 510
        cycle(1, 0, 1, 1);
        cycle(1, 0, 1, 1);
        repeat (510) cycle(0, 1, 1, 1);
        cycle(0, 1, 5, 1);
        check("step5_addr_510", int'(bus.rom_addr), 1);
        cycle(0, 1, 5, 1);
        check("step5_addr_3", int'(bus.rom_addr), 3);
        cycle(0, 1, 5, 1);
        check("step5_sample_507", int'(bus.sample), 507);
        cycle(0, 1, 5, 1);
        check("step5_sample_rom3", int'(bus.sample), 12);

        // Fill the FIFO, then reset for one cycle while it is full
        repeat (8) cycle(0, 1, 1, 0);
        check("full_valid", int'(bus.sample_valid), 1);
        @(negedge clk);
        i_reset = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 9'($urandom_range(0, 511));
        @(posedge clk);
        #1;
        check("midreset_valid", int'(bus.sample_valid), 0);
        check("midreset_sample", int'(bus.sample), 0);
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            cycle(0, 1, 1, 1);
            if (bus.sample_valid) begin
                found = 1;
                check("post_reset_first", int'(bus.sample), int'(rom[0]));
            end
        end
        check("post_reset_seen", found, 1);

        // step=0 holds the phase at 0
        cycle(1, 0, 0, 1);
        for (int c = 0; c < 20; c++) begin
            cycle(0, 1, 0, 1);
            check("step0_addr", int'(bus.rom_addr), 0);
            if (bus.sample_valid) check("step0_sample", int'(bus.sample), int'(rom[0]));
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) i_step = 7'($urandom_range(0, 127));
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 4) != 0,
                  int'(i_step),
                  $urandom_range(0, 9) < 7);
        end
        repeat (10) cycle(0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
